// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - round-robin 7-segment scan controller sharing one external decoder
// Per-digit code file, blank-then-lit slot timing, registered pins driven from next-state.
module seg_scan_ctrl #(
    parameter int         NUM_DIGITS   = 8,
    parameter int         AW           = 3,
    parameter int         DIV_CYCLES   = 1000,
    parameter int         BLANK_CYCLES = 50,
    parameter logic [6:0] BLANK_SEG    = 7'b1111111
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_en,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [2:0]            wr_data,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [2:0]            dec_code,
    input  logic [6:0]            dec_seg,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] digit_en_n,
    output logic [AW-1:0]         cur_digit,
    output logic                  frame_done
);

    localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [AW-1:0]         r_cur_digit;
    logic [2:0]            r_code [NUM_DIGITS];
    logic [2:0]            r_dec_code;
    logic                  r_mask_q;
    logic [6:0]            r_seg_out;
    logic [NUM_DIGITS-1:0] r_digit_en_n;
    logic                  r_frame_done;

    state_t                w_state_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [AW-1:0]         w_digit_nxt;
    logic                  w_latch;
    logic                  w_frame_end;
    logic [2:0]            w_code_sel;
    logic                  w_mask_sel;
    logic [6:0]            w_seg_nxt;
    logic [NUM_DIGITS-1:0] w_en_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cur_digit <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cur_digit <= w_digit_nxt;
        end
    end

    // Dropping scan_en overrides everything; cur_digit is held so the slot restarts later.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_digit_nxt = r_cur_digit;
        w_latch     = 1'b0;
        w_frame_end = 1'b0;
        if (!scan_en) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = '0;
                    w_latch     = 1'b1;
                end
                S_BLANK: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
                        w_state_nxt = S_ON;
                    end
                end
                S_ON: begin
                    if (r_cnt == CW'(DIV_CYCLES - 1)) begin
                        w_state_nxt = S_BLANK;
                        w_cnt_nxt   = '0;
                        w_latch     = 1'b1;
                        w_frame_end = (r_cur_digit == AW'(NUM_DIGITS - 1));
                        w_digit_nxt = w_frame_end ? '0 : r_cur_digit + 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_code_sel = '0;
        w_mask_sel = 1'b0;
        w_seg_nxt  = BLANK_SEG;
        w_en_nxt   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_digit_nxt == AW'(i)) begin
                w_code_sel = r_code[i];
                w_mask_sel = digit_mask[i];
            end
        end
        if (w_state_nxt == S_ON) begin
            w_seg_nxt = dec_seg;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_digit_nxt == AW'(i)) begin
                    w_en_nxt[i] = ~r_mask_q;
                end
            end
        end
    end

    // Slot latch reads the code file before this edge's write lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_code[i] <= '0;
            end
            r_dec_code   <= '0;
            r_mask_q     <= 1'b0;
            r_seg_out    <= BLANK_SEG;
            r_digit_en_n <= '1;
            r_frame_done <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    r_code[i] <= wr_data;
                end
            end
            if (w_latch) begin
                r_dec_code <= w_code_sel;
                r_mask_q   <= w_mask_sel;
            end
            r_seg_out    <= w_seg_nxt;
            r_digit_en_n <= w_en_nxt;
            r_frame_done <= w_frame_end;
        end
    end

    assign dec_code   = r_dec_code;
    assign seg_out    = r_seg_out;
    assign digit_en_n = r_digit_en_n;
    assign cur_digit  = r_cur_digit;
    assign frame_done = r_frame_done;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one combinational 3-bit-to-7-segment decoder across NUM_DIGITS common-anode digits. It holds a per-digit code register file written by the core logic. It cycles round-robin through the digits, presenting each code to the shared decoder, and drives the digit enables with a blanking gap before each digit lights. The block sits between the application logic and the board display pins; the decoder sits outside it on the dec_code/dec_seg loop.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (2..8)
AW, 3, width of wr_addr and cur_digit; must satisfy 2**AW >= NUM_DIGITS
DIV_CYCLES, 1000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 50, cycles at the start of each slot with all digits off (1 <= BLANK_CYCLES < DIV_CYCLES)
BLANK_SEG, 7'b1111111, segment pattern driven while blanked

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low
scan_en  input  1  1 = scanning runs; 0 = display off, scan position frozen
wr_en  input  1  write strobe for the code register file
wr_addr  input  AW  digit index to write
wr_data  input  3  code for that digit
digit_mask  input  NUM_DIGITS  1 = digit may light; sampled at slot start
dec_code  output  3  code presented to the shared decoder (registered)
dec_seg  input  7  decoder result for dec_code (combinational return)
seg_out  output  7  registered segment pins
digit_en_n  output  NUM_DIGITS  registered digit enables, active-low, at most one low
cur_digit  output  AW  index of the current slot
frame_done  output  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- Reset (rst_n=0 at a clk edge): all code registers = 0; state = IDLE; cnt = 0; cur_digit = 0; dec_code = 0; seg_out = BLANK_SEG; digit_en_n = all 1s; frame_done = 0; latched mask = 0. Reset mid-slot takes effect on that edge, with no partial slot completion.
- Register file: on an edge with wr_en=1 and wr_addr < NUM_DIGITS, code[wr_addr] <= wr_data. Writes with wr_addr >= NUM_DIGITS are ignored. A write never alters the slot already in progress.
- Slot-start latch: on entry to BLANK, dec_code <= code[cur_digit] and mask_q <= digit_mask[cur_digit]. If a write to the same index happens on that same edge, the latch takes the pre-write value; the new value appears on that digit's next slot.
- cnt runs 0..DIV_CYCLES-1 across a slot and is held at 0 in IDLE.
- FSM states: IDLE, BLANK, ON.
  - IDLE: digit_en_n all 1s, seg_out = BLANK_SEG. When scan_en=1, go to BLANK for the current cur_digit with cnt=0 and latch.
  - BLANK: digit_en_n all 1s, seg_out = BLANK_SEG. When cnt == BLANK_CYCLES-1, go to ON.
  - ON: digit_en_n[cur_digit] = ~mask_q and all other bits = 1. seg_out <= dec_seg on every ON cycle; dec_code is stable for the whole slot. When cnt == DIV_CYCLES-1, go to BLANK with cur_digit = cur_digit+1, wrapping NUM_DIGITS-1 -> 0, and perform the slot-start latch.
- Output timing: digit_en_n and seg_out are registered from next-state, so both change on the same edge. There is no cycle where an enable is low with stale segments.
- frame_done = 1 for exactly the cycle after the edge that leaves ON of digit NUM_DIGITS-1 (the first BLANK cycle of digit 0).
- scan_en=0 in any state: IDLE on the next edge with outputs blanked and cnt = 0. cur_digit is held, so re-enabling restarts that digit's slot from BLANK. frame_done is not pulsed.
- A masked digit still consumes its full slot, so frame period = NUM_DIGITS*DIV_CYCLES regardless of mask. An all-zero mask gives a dark display with normal timing.

Test Plan:
Use NUM_DIGITS=4, DIV_CYCLES=8, BLANK_CYCLES=2, and a bench decoder model seg = {4'b0, code}.
- Reset then scan_en=1 with mask=4'hF and no writes -> per 8-cycle slot: 2 cycles digit_en_n=4'hF with seg_out=7'h7F, then 6 cycles digit_en_n=4'hE/D/B/7 in turn with seg_out=7'h00. frame_done pulses every 32 cycles.
- Write codes 5,3,7,1 to addr 0..3 -> lit slots show seg_out 7'h05, 7'h03, 7'h07, 7'h01 in order; exactly one digit_en_n bit low.
- Write addr 2 = 6 on the same edge digit 2 enters BLANK -> that slot shows 7'h07 (old value); the next frame shows 7'h06. Write addr 5 -> no register changes.
- digit_mask=4'b0101 -> digits 1 and 3 stay high through their slots; frame_done period remains 32 cycles.
- Drop scan_en for 3 cycles in the ON phase of digit 2 -> blanked the next cycle; on re-enable, digit 2 restarts with 2 blank + 6 lit cycles.
- Assert rst_n=0 mid-ON for one edge -> all outputs return to reset values and codes read back as 0 on the next scan.
